diagonal_skew_feeder: RTL

//   Sits directly upstream of the 48-bit diagonal delay pipeline and produces its input_diagonal word.

---
 rtl/diag_pkg.sv | 30 +++
 rtl/diag_tile_buf.sv | 36 +++
 rtl/diagonal_skew_feeder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/diag_pkg.sv
// Shared sizes, FSM state type and lane helpers for the diagonal skew feeder.
package diag_pkg;

  localparam int unsigned LANE_W = 16;
  localparam int unsigned LANES  = 3;
  localparam int unsigned DIAG_W = LANES * LANE_W;
  localparam int unsigned STEP_W = $clog2(2 * LANES);
  localparam int unsigned NSTEPS = 2 * LANES - 1;

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Extract lane k of a packed row/diagonal word.
  function automatic logic [LANE_W-1:0] lane_slice(input logic [DIAG_W-1:0] word,
                                                   input int unsigned       k);
    return word[k*LANE_W +: LANE_W];
  endfunction

  // True when lane k at drain step s reads tile row r; the extra sign bit stops s-k wrapping.
  function automatic logic row_hit(input logic [STEP_W-1:0] s,
                                   input int unsigned       k,
                                   input int unsigned       r);
    logic [STEP_W+1:0] d;
    d = {2'b00, s} - (STEP_W+2)'(k);
    return !d[STEP_W+1] && (d == (STEP_W+2)'(r));
  endfunction

endpackage

// File: rtl/diag_tile_buf.sv
// LANES x LANES tile register array: row-indexed write, per-lane skewed read with zero mask.
module diag_tile_buf
  import diag_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_wr_en,
  input  logic [STEP_W-1:0] i_wr_row,
  input  logic [DIAG_W-1:0] i_wr_data,
  input  logic [STEP_W-1:0] i_rd_step,
  output logic [DIAG_W-1:0] o_rd_word
);

  logic [DIAG_W-1:0] r_rows [LANES];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < int'(LANES); r++) r_rows[r] <= '0;
    end else begin
      for (int r = 0; r < int'(LANES); r++) begin
        if (i_wr_en && (i_wr_row == STEP_W'(r))) r_rows[r] <= i_wr_data;
      end
    end
  end

  // Lane k takes A[s-k][k]; lanes whose row falls outside the tile stay zero.
  always_comb begin
    o_rd_word = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      for (int r = 0; r < int'(LANES); r++) begin
        if (row_hit(i_rd_step, k, r)) o_rd_word[k*LANE_W +: LANE_W] = lane_slice(r_rows[r], k);
      end
    end
  end

endmodule

// File: rtl/diagonal_skew_feeder.sv
// Loads a LANES x LANES tile row by row and drains it as 2*LANES-1 skewed diagonal words.
// Optional DIAG_TILE_CNT_EN adds a 16-bit count of completed tiles on tile_count.
module diagonal_skew_feeder
  import diag_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIAG_W-1:0] in_row,
  input  logic              abort,
  output logic [DIAG_W-1:0] output_diagonal,
  output logic              diag_valid,
  output logic              tile_last
`ifdef DIAG_TILE_CNT_EN
  ,
  output logic [15:0]       tile_count
`endif
);

  state_e            r_state, w_state_nxt;
  logic [STEP_W-1:0] r_row_cnt, w_row_cnt_nxt;
  logic [STEP_W-1:0] r_step, w_step_nxt;
  logic [DIAG_W-1:0] r_diag, w_diag_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_last, w_last_nxt;
  logic              w_accept;
  logic [STEP_W-1:0] w_rd_step;
  logic [DIAG_W-1:0] w_rd_word;

  // Ready is low in reset, while draining, and in any abort cycle.
  assign in_ready  = reset_n && (r_state == LOAD) && !abort;
  assign w_accept  = in_valid && in_ready;
  assign w_rd_step = (r_state == LOAD) ? '0 : r_step;

  diag_tile_buf u_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_wr_en   (w_accept),
    .i_wr_row  (r_row_cnt),
    .i_wr_data (in_row),
    .i_rd_step (w_rd_step),
    .o_rd_word (w_rd_word)
  );

  // r_step is one ahead of the word on the output: step 0 is registered by the last row handshake.
  always_comb begin
    w_state_nxt   = r_state;
    w_row_cnt_nxt = r_row_cnt;
    w_step_nxt    = r_step;
    w_diag_nxt    = '0;
    w_valid_nxt   = 1'b0;
    w_last_nxt    = 1'b0;
    if (abort) begin
      w_state_nxt   = LOAD;
      w_row_cnt_nxt = '0;
      w_step_nxt    = '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_accept) begin
            if (r_row_cnt == STEP_W'(LANES - 1)) begin
              w_state_nxt   = DRAIN;
              w_row_cnt_nxt = '0;
              w_step_nxt    = STEP_W'(1);
              w_diag_nxt    = w_rd_word;
              w_valid_nxt   = 1'b1;
            end else begin
              w_row_cnt_nxt = r_row_cnt + STEP_W'(1);
            end
          end
        end
        DRAIN: begin
          if (r_step == STEP_W'(NSTEPS)) begin
            w_state_nxt = LOAD;
            w_step_nxt  = '0;
          end else begin
            w_diag_nxt  = w_rd_word;
            w_valid_nxt = 1'b1;
            w_last_nxt  = (r_step == STEP_W'(NSTEPS - 1));
            w_step_nxt  = r_step + STEP_W'(1);
          end
        end
        default: begin
          w_state_nxt   = LOAD;
          w_row_cnt_nxt = '0;
          w_step_nxt    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= LOAD;
      r_row_cnt <= '0;
      r_step    <= '0;
      r_diag    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_row_cnt <= w_row_cnt_nxt;
      r_step    <= w_step_nxt;
      r_diag    <= w_diag_nxt;
      r_valid   <= w_valid_nxt;
      r_last    <= w_last_nxt;
    end
  end

  assign output_diagonal = r_diag;
  assign diag_valid      = r_valid;
  assign tile_last       = r_last;

`ifdef DIAG_TILE_CNT_EN
  logic [15:0] r_tile_cnt;

  // Counts with the final word; an aborted tile never reaches it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        r_tile_cnt <= '0;
    else if (w_last_nxt) r_tile_cnt <= r_tile_cnt + 16'd1;
  end

  assign tile_count = r_tile_cnt;
`endif

endmodule
